// File: rtl/mem_pkg.sv
// Shared types and constants for the memory read-channel arbiter.
//   state_t    : arbiter FSM states
//   resp_t     : AXI read response codes
//   BURST_INCR : AXI INCR burst encoding
//   axi_size() : AXI size field for a given data-bus width in bits
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   localparam logic [1:0] BURST_INCR = 2'b01;

   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// i_ptr, wrapping modulo NUM_M. The pointer register lives in the parent.
//   i_req       : request vector
//   i_ptr       : index of the highest-priority requester this cycle
//   o_grant     : one-hot grant
//   o_grant_idx : binary index of the granted requester
//   o_any       : at least one request present
module rr_arbiter #(
   parameter int NUM_M = 2,
   parameter int IDX_W = 1
) (
   input  logic [NUM_M-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NUM_M-1:0] o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_any
);

   // Scan offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         for (int j = 0; j < NUM_M; j++) begin
            if ((j == ((int'(i_ptr) + k) % NUM_M)) && i_req[j]) begin
               o_grant     = '0;
               o_grant[j]  = 1'b1;
               o_grant_idx = IDX_W'(j);
               o_any       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares the AXI4 AR/R channels of a single memory slave between NUM_M
// requesters. Round-robin grant per burst, one burst outstanding; the slave
// provides no r_last, so beats are counted against the latched length.
//
// Ports:
//   clk, rst (async, active-low)
//   s_ar_*  : packed requester AR side (slice i = requester i)
//   s_r_*   : packed requester R side (data/resp broadcast, valid/last steered)
//   ar_*    : AR channel to memory
//   r_*     : R channel from memory
//   err_id  : sticky r_id mismatch flag
//
// Optional build macro MEM_RD_ARB_RID_CHECK_EN: compares r_id with the granted
// index on each beat; a mismatch sets err_id and forces SLVERR on that beat.
// Without it r_id is ignored, err_id is 0 and r_resp passes through.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// ADDR  | AR presented to memory, waiting for ar_ready
// DATA  | routing beats to the granted requester until len+1 handshakes
module mem_rd_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_M         = 2,
   parameter int ID_WIDTH      = 1,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_M*ADDRESS_WIDTH-1:0] s_ar_addr,
   input  logic [NUM_M*8-1:0]            s_ar_len,
   input  logic [NUM_M-1:0]              s_ar_valid,
   output logic [NUM_M-1:0]              s_ar_ready,
   output logic [NUM_M*DATA_WIDTH-1:0]   s_r_data,
   output logic [NUM_M*2-1:0]            s_r_resp,
   output logic [NUM_M-1:0]              s_r_last,
   output logic [NUM_M-1:0]              s_r_valid,
   input  logic [NUM_M-1:0]              s_r_ready,
   output logic [ID_WIDTH-1:0]           ar_id,
   output logic [ADDRESS_WIDTH-1:0]      ar_addr,
   output logic [7:0]                    ar_len,
   output logic [2:0]                    ar_size,
   output logic [1:0]                    ar_burst,
   output logic                          ar_valid,
   input  logic                          ar_ready,
   input  logic [ID_WIDTH-1:0]           r_id,
   input  logic [DATA_WIDTH-1:0]         r_data,
   input  logic [1:0]                    r_resp,
   input  logic                          r_valid,
   output logic                          r_ready,
   output logic                          err_id
);

   localparam int IDX_W = $clog2(NUM_M);

   state_t                     r_state, w_state_nxt;
   logic [IDX_W-1:0]           r_ptr;
   logic [NUM_M-1:0]           r_gnt_oh;
   logic [ID_WIDTH-1:0]        r_g;
   logic [ADDRESS_WIDTH-1:0]   r_addr;
   logic [7:0]                 r_len;
   logic [7:0]                 r_beat_cnt;
   logic                       r_ar_valid;

   logic [NUM_M-1:0]           w_grant;
   logic [IDX_W-1:0]           w_grant_idx;
   logic                       w_any;
   logic [ADDRESS_WIDTH-1:0]   w_sel_addr;
   logic [7:0]                 w_sel_len;
   logic [IDX_W-1:0]           w_ptr_nxt;
   logic                       w_in_data;
   logic                       w_r_hs;
   logic                       w_last_beat;
   logic [1:0]                 w_resp;

   rr_arbiter #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req       (s_ar_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_len  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = s_ar_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_sel_len  = s_ar_len[i*8 +: 8];
         end
      end
   end

   assign w_ptr_nxt   = (w_grant_idx == IDX_W'(NUM_M - 1)) ? '0 : w_grant_idx + IDX_W'(1);
   assign w_in_data   = (r_state == DATA);
   assign w_r_hs      = r_valid & r_ready;
   assign w_last_beat = (r_beat_cnt == r_len);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = ADDR;
         ADDR:    if (r_ar_valid && ar_ready) w_state_nxt = DATA;
         DATA:    if (w_r_hs && w_last_beat) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr      <= '0;
         r_gnt_oh   <= '0;
         r_g        <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_beat_cnt <= '0;
         r_ar_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_addr     <= w_sel_addr;
                  r_len      <= w_sel_len;
                  r_g        <= ID_WIDTH'(w_grant_idx);
                  r_gnt_oh   <= w_grant;
                  r_ptr      <= w_ptr_nxt;
                  r_ar_valid <= 1'b1;
               end
            end
            ADDR: begin
               if (r_ar_valid && ar_ready) begin
                  r_ar_valid <= 1'b0;
                  r_beat_cnt <= '0;
               end
            end
            DATA: begin
               if (w_r_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // rst gates the grant so a request held during reset is not acknowledged.
   assign s_ar_ready = {NUM_M{(r_state == IDLE) & rst}} & w_grant;

   assign ar_id    = r_g;
   assign ar_addr  = r_addr;
   assign ar_len   = r_len;
   assign ar_size  = axi_size(DATA_WIDTH);
   assign ar_burst = BURST_INCR;
   assign ar_valid = r_ar_valid;

   assign r_ready   = w_in_data & (|(s_r_ready & r_gnt_oh));
   assign s_r_valid = {NUM_M{w_in_data & r_valid}} & r_gnt_oh;
   assign s_r_last  = {NUM_M{w_in_data & r_valid & w_last_beat}} & r_gnt_oh;
   assign s_r_data  = {NUM_M{r_data}};
   assign s_r_resp  = {NUM_M{w_resp}};

`ifdef MEM_RD_ARB_RID_CHECK_EN
   logic w_rid_bad;
   logic r_err_id;

   assign w_rid_bad = w_in_data & r_valid & (r_id != r_g);
   assign w_resp    = w_rid_bad ? RESP_SLVERR : r_resp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_err_id <= 1'b0;
      else if (w_rid_bad && w_r_hs) r_err_id <= 1'b1;
   end

   assign err_id = r_err_id;
`else
   logic w_unused_rid;

   assign w_unused_rid = ^r_id;
   assign w_resp       = r_resp;
   assign err_id       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter (NUM_M=2, ID_WIDTH=1, 32-bit address,
// 64-bit data). Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
module tb_mem_rd_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   s_ar_addr;
   logic [15:0]   s_ar_len;
   logic [1:0]    s_ar_valid;
   logic [1:0]    s_ar_ready;
   logic [127:0]  s_r_data;
   logic [3:0]    s_r_resp;
   logic [1:0]    s_r_last;
   logic [1:0]    s_r_valid;
   logic [1:0]    s_r_ready;
   logic [0:0]    ar_id;
   logic [31:0]   ar_addr;
   logic [7:0]    ar_len;
   logic [2:0]    ar_size;
   logic [1:0]    ar_burst;
   logic          ar_valid;
   logic          ar_ready;
   logic [0:0]    r_id;
   logic [63:0]   r_data;
   logic [1:0]    r_resp;
   logic          r_valid;
   logic          r_ready;
   logic          err_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_rd_arbiter #(
      .NUM_M (2), .ID_WIDTH (1), .ADDRESS_WIDTH (32), .DATA_WIDTH (64)
   ) dut (
      .clk (clk), .rst (rst),
      .s_ar_addr (s_ar_addr), .s_ar_len (s_ar_len), .s_ar_valid (s_ar_valid),
      .s_ar_ready (s_ar_ready), .s_r_data (s_r_data), .s_r_resp (s_r_resp),
      .s_r_last (s_r_last), .s_r_valid (s_r_valid), .s_r_ready (s_r_ready),
      .ar_id (ar_id), .ar_addr (ar_addr), .ar_len (ar_len), .ar_size (ar_size),
      .ar_burst (ar_burst), .ar_valid (ar_valid), .ar_ready (ar_ready),
      .r_id (r_id), .r_data (r_data), .r_resp (r_resp), .r_valid (r_valid),
      .r_ready (r_ready), .err_id (err_id)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a request from IDLE, check the grant, then the AR phase.
   // Leaves ar_ready=1 so the address handshake happens on the next edge.
   task automatic req(input logic [1:0] vld, input logic [1:0] exp_rdy,
                      input logic exp_id, input logic [31:0] exp_addr,
                      input logic [7:0] exp_len, input int hold, input bit keep);
      @(negedge clk);
      ar_ready = 1'b0; s_ar_valid = vld; r_valid = 1'b1; s_r_ready = 2'b11;
      #1;
      chk("idle_s_r_valid", s_r_valid, 2'b00);
      chk("idle_r_ready", r_ready, 1'b0);
      chk("grant_s_ar_ready", s_ar_ready, exp_rdy);
      chk("idle_ar_valid", ar_valid, 1'b0);
      @(negedge clk);
      if (!keep) s_ar_valid = 2'b00;
      #1;
      chk("addr_ar_valid", ar_valid, 1'b1);
      chk("addr_ar_id", ar_id, exp_id);
      chk("addr_ar_addr", ar_addr, exp_addr);
      chk("addr_ar_len", ar_len, exp_len);
      chk("addr_ar_size", ar_size, 3'd3);
      chk("addr_ar_burst", ar_burst, 2'b01);
      chk("addr_s_ar_ready", s_ar_ready, 2'b00);
      chk("addr_s_r_valid", s_r_valid, 2'b00);
      chk("addr_r_ready", r_ready, 1'b0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         chk("hold_ar_valid", ar_valid, 1'b1);
         chk("hold_ar_addr", ar_addr, exp_addr);
         chk("hold_ar_len", ar_len, exp_len);
      end
      ar_ready = 1'b1;
   endtask

   task automatic beat(input logic [1:0] rdy, input logic [63:0] d,
                       input logic [1:0] resp, input logic rid,
                       input logic [1:0] exp_vld, input logic exp_rr,
                       input logic [1:0] exp_last, input logic [1:0] exp_resp);
      @(negedge clk);
      ar_ready = 1'b0; r_valid = 1'b1; r_data = d; r_resp = resp;
      r_id = rid; s_r_ready = rdy;
      #1;
      chk("beat_s_r_valid", s_r_valid, exp_vld);
      chk("beat_r_ready", r_ready, exp_rr);
      chk("beat_s_r_last", s_r_last, exp_last);
      chk("beat_s_r_data", s_r_data, {d, d});
      chk("beat_s_r_resp", s_r_resp, {exp_resp, exp_resp});
      chk("beat_ar_valid", ar_valid, 1'b0);
      chk("beat_s_ar_ready", s_ar_ready, 2'b00);
   endtask

   initial begin
      rst = 1'b0; s_ar_addr = '0; s_ar_len = '0; s_ar_valid = 2'b01;
      s_r_ready = '0; ar_ready = 1'b0; r_id = '0; r_data = '0; r_resp = '0;
      r_valid = 1'b0;
      @(negedge clk); #1;
      chk("rst_ar_valid", ar_valid, 1'b0);
      chk("rst_ar_addr", ar_addr, 32'h0);
      chk("rst_ar_len", ar_len, 8'h0);
      chk("rst_ar_id", ar_id, 1'b0);
      chk("rst_s_ar_ready", s_ar_ready, 2'b00);
      chk("rst_s_r_valid", s_r_valid, 2'b00);
      chk("rst_r_ready", r_ready, 1'b0);
      chk("rst_err_id", err_id, 1'b0);
      @(negedge clk);
      rst = 1'b1; s_ar_valid = 2'b00;

      // Single request from requester 0, len=3, AR held one extra cycle.
      s_ar_addr[31:0] = 32'h100; s_ar_len[7:0] = 8'd3;
      req(2'b01, 2'b01, 1'b0, 32'h100, 8'd3, 1, 1'b0);
      beat(2'b01, 64'hA0, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00);
      beat(2'b01, 64'hA1, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 2'b11);
      beat(2'b01, 64'hA2, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00);
      beat(2'b01, 64'hA3, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00);

      // Back-pressure on requester 1, len=1: ready pattern 1,0,0,1.
      s_ar_addr[63:32] = 32'h180; s_ar_len[15:8] = 8'd1;
      req(2'b10, 2'b10, 1'b1, 32'h180, 8'd1, 0, 1'b0);
      beat(2'b10, 64'hB0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00);
      beat(2'b00, 64'hB1, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10, 2'b00);
      beat(2'b00, 64'hB1, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10, 2'b00);
      beat(2'b10, 64'hB1, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00);

      // Contention, both held, len=0: order 0,1,0,1.
      s_ar_addr = {32'h300, 32'h200}; s_ar_len = 16'h0000;
      req(2'b11, 2'b01, 1'b0, 32'h200, 8'd0, 0, 1'b1);
      beat(2'b01, 64'hC0, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00);
      req(2'b11, 2'b10, 1'b1, 32'h300, 8'd0, 0, 1'b1);
      beat(2'b10, 64'hC1, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00);
      req(2'b11, 2'b01, 1'b0, 32'h200, 8'd0, 0, 1'b1);
      beat(2'b01, 64'hC2, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00);
      req(2'b11, 2'b10, 1'b1, 32'h300, 8'd0, 0, 1'b1);
      beat(2'b10, 64'hC3, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00);

      // Max burst, len=255 from requester 0.
      s_ar_addr[31:0] = 32'h1000; s_ar_len[7:0] = 8'd255;
      req(2'b01, 2'b01, 1'b0, 32'h1000, 8'd255, 0, 1'b0);
      for (int k = 0; k < 256; k++)
         beat(2'b01, 64'(k), 2'b00, 1'b0, 2'b01, 1'b1,
              (k == 255) ? 2'b01 : 2'b00, 2'b00);

      // Reset in the middle of a len=7 burst.
      s_ar_addr[31:0] = 32'h2000; s_ar_len[7:0] = 8'd7;
      req(2'b01, 2'b01, 1'b0, 32'h2000, 8'd7, 0, 1'b0);
      beat(2'b01, 64'hD0, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00);
      beat(2'b01, 64'hD1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
      rst = 1'b0; r_valid = 1'b1; s_r_ready = 2'b11; s_ar_valid = 2'b11; ar_ready = 1'b1;
      #1;
      chk("mrst_ar_valid", ar_valid, 1'b0);
      chk("mrst_ar_addr", ar_addr, 32'h0);
      chk("mrst_ar_len", ar_len, 8'h0);
      chk("mrst_ar_id", ar_id, 1'b0);
      chk("mrst_s_ar_ready", s_ar_ready, 2'b00);
      chk("mrst_s_r_valid", s_r_valid, 2'b00);
      chk("mrst_s_r_last", s_r_last, 2'b00);
      chk("mrst_r_ready", r_ready, 1'b0);
      chk("mrst_err_id", err_id, 1'b0);
      @(negedge clk);
      rst = 1'b1; s_ar_valid = 2'b00; ar_ready = 1'b0; r_valid = 1'b0;
      s_ar_addr[63:32] = 32'h400; s_ar_len[15:8] = 8'd0;
      req(2'b10, 2'b10, 1'b1, 32'h400, 8'd0, 0, 1'b0);
      beat(2'b10, 64'hE0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00);

      // r_id mismatch on grant 0, len=1.
      s_ar_addr[31:0] = 32'h500; s_ar_len[7:0] = 8'd1;
      req(2'b01, 2'b01, 1'b0, 32'h500, 8'd1, 0, 1'b0);
`ifdef MEM_RD_ARB_RID_CHECK_EN
      beat(2'b01, 64'hF0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 2'b10);
      chk("rid_err_before", err_id, 1'b0);
      beat(2'b01, 64'hF1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00);
      chk("rid_err_set", err_id, 1'b1);
      @(negedge clk); r_valid = 1'b0; #1;
      chk("rid_err_sticky", err_id, 1'b1);
`else
      beat(2'b01, 64'hF0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00);
      chk("rid_err_before", err_id, 1'b0);
      beat(2'b01, 64'hF1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00);
      chk("rid_err_tied", err_id, 1'b0);
      @(negedge clk); r_valid = 1'b0; #1;
      chk("rid_err_tied_idle", err_id, 1'b0);
`endif
      @(negedge clk); rst = 1'b0; #1;
      chk("final_rst_err_id", err_id, 1'b0);
      @(negedge clk); rst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
Shares the AXI4 read channels (AR/R) of the single `memory` slave between NUM_M requesters.
- Round-robin arbitration, granted per burst.
- One burst is outstanding at a time.
- The slave has no r_last, so the block counts beats against the latched length.
- It sits between the requester fabric and the memory instance. The memory's write channels bypass this block.

Parameters:
NUM_M, 2, number of requesters (2..4).
ID_WIDTH, 1, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_M.
ADDRESS_WIDTH, 32, address width.
DATA_WIDTH, 64, data width (power of 2, >= 8).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
s_ar_addr  in  NUM_M*ADDRESS_WIDTH  packed requester addresses; requester i occupies slice i
s_ar_len  in  NUM_M*8  packed burst lengths (beats-1)
s_ar_valid  in  NUM_M  request valid
s_ar_ready  out  NUM_M  request accepted
s_r_data  out  NUM_M*DATA_WIDTH  read data; all slices carry r_data
s_r_resp  out  NUM_M*2  response; all slices carry the response
s_r_last  out  NUM_M  generated last-beat flag
s_r_valid  out  NUM_M  beat valid; only the granted bit can be 1
s_r_ready  in  NUM_M  beat ready
ar_id  out  ID_WIDTH  granted requester index
ar_addr  out  ADDRESS_WIDTH  to memory
ar_len  out  8  to memory
ar_size  out  3  constant log2(DATA_WIDTH/8)
ar_burst  out  2  constant INCR (2'b01)
ar_valid  out  1  to memory
ar_ready  in  1  from memory
r_id  in  ID_WIDTH  from memory
r_data  in  DATA_WIDTH  from memory
r_resp  in  2  from memory
r_valid  in  1  from memory
r_ready  out  1  to memory
err_id  out  1  sticky r_id mismatch flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ar_valid=0; ar_addr=0; ar_len=0; ar_id=0.
  - Round-robin pointer=0; beat_cnt=0; err_id=0.
  - s_ar_ready=0; s_r_valid=0; r_ready=0.
  - Reset mid-burst abandons the burst; no cleanup beats are issued.
- FSM IDLE:
  - If any s_ar_valid is high, pick the first set bit at or after the pointer, wrapping modulo NUM_M.
  - s_ar_ready[g]=1 combinationally in that same cycle.
  - Latch addr, len and g; set pointer=(g+1) mod NUM_M; go to ADDR.
  - Simultaneous requests: only one is granted per IDLE cycle; the others wait with s_ar_ready=0.
- FSM ADDR:
  - ar_valid=1 (registered; rises the cycle after the grant). AR fields are held stable.
  - On ar_valid&&ar_ready: ar_valid=0; beat_cnt=0; go to DATA.
- FSM DATA:
  - r_ready=s_r_ready[g]; s_r_valid[g]=r_valid; other s_r_valid bits are 0.
  - s_r_last[g]=(beat_cnt==latched len) while s_r_valid[g] is high.
  - beat_cnt increments on each r_valid&&r_ready.
  - On the handshake of the final beat, go to IDLE. A new grant is possible in the next cycle.
- r_valid in IDLE/ADDR: ignored, r_ready=0.
- Boundaries:
  - len=0: exactly one beat.
  - len=255: 256 beats; beat_cnt is 8 bits and never wraps inside a burst.
- Minimum latency: s_ar_valid accepted at cycle N; ar_valid at N+1; first beat at N+2 at the earliest.
- s_ar_valid dropping after acceptance has no effect; the request is already latched.

Optional Feature:
MEM_RD_ARB_RID_CHECK_EN
- Defined: in DATA, r_id!=latched g on a beat handshake sets err_id=1 (sticky until reset). That beat's s_r_resp is forced to SLVERR (2'b10).
- Undefined: r_id is ignored, err_id is tied 0, and r_resp passes through unchanged.

Decomposition:
- Package mem_pkg: state enum {IDLE, ADDR, DATA}; BURST_INCR, RESP_OKAY, RESP_SLVERR constants; function axi_size(DATA_WIDTH).
- Sub-module rr_arbiter (NUM_M; inputs req, ptr; outputs grant one-hot, grant index, any). Purely combinational; the pointer register lives in mem_rd_arbiter.

Test Plan:
- Single request: s_ar_valid=01, addr=0x100, len=3 -> ar_id=0, ar_addr=0x100, ar_len=3, ar_size=3, ar_burst=1. Four beats reach requester 0 only; s_r_last on the 4th beat; FSM back in IDLE.
- Contention: s_ar_valid=11 held over 4 bursts (len=0) -> grant order 0,1,0,1; the loser's s_ar_ready stays 0 until its turn.
- Back-pressure: s_r_ready[g] toggles 1,0,0,1 with r_valid steady -> r_ready mirrors it, beat_cnt advances only on handshakes, no beat lost or duplicated.
- Max burst: len=255 -> exactly 256 handshakes; s_r_last only on the 256th; ar_valid stays 0 throughout DATA.
- Reset mid-burst: rst=0 after beat 2 of len=7 -> all outputs at reset values within the same cycle. After release, a new request from requester 1 is granted with ar_id=1.
- With MEM_RD_ARB_RID_CHECK_EN: grant 0, memory returns r_id=1 -> err_id=1 and s_r_resp=2'b10 on that beat; err_id stays 1 until reset.
